// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
package fetch_pkg;

    localparam int unsigned PC_WIDTH_DEF   = 20;
    localparam int unsigned INSN_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory read, IR register and
// decode handshake, with branch redirect and halt at instruction boundaries.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned         PC_WIDTH   = PC_WIDTH_DEF,
    parameter int unsigned         INSN_WIDTH = INSN_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  halt,
    input  logic                  redirect,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  mem_req,
    output logic [PC_WIDTH-1:0]   mem_addr,
    input  logic                  mem_ack,
    input  logic [INSN_WIDTH-1:0] mem_rdata,
    output logic                  insn_valid,
    input  logic                  insn_ready,
    output logic [INSN_WIDTH-1:0] insn,
    output logic [PC_WIDTH-1:0]   insn_pc,
    output logic                  busy
);

    fetch_state_e          state, state_next;
    logic [PC_WIDTH-1:0]   pc, pc_next;
    logic                  pend_valid, pend_valid_next;
    logic [PC_WIDTH-1:0]   pend_pc, pend_pc_next;
    logic [INSN_WIDTH-1:0] insn_next;
    logic [PC_WIDTH-1:0]   insn_pc_next;
    logic                  insn_valid_next;
    logic                  mem_req_next;
    logic                  busy_next;

    // The request address is the PC itself; PC only moves on ack, so it is stable.
    assign mem_addr = pc;

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            insn       <= '0;
            insn_pc    <= '0;
            insn_valid <= 1'b0;
            mem_req    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pend_valid <= pend_valid_next;
            pend_pc    <= pend_pc_next;
            insn       <= insn_next;
            insn_pc    <= insn_pc_next;
            insn_valid <= insn_valid_next;
            mem_req    <= mem_req_next;
            busy       <= busy_next;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        pend_valid_next = pend_valid;
        pend_pc_next    = pend_pc;
        insn_next       = insn;
        insn_pc_next    = insn_pc;
        insn_valid_next = insn_valid;

        case (state)
            IDLE: begin
                if (redirect) pc_next = redirect_pc;
                if (!halt)    state_next = FETCH;
            end
            FETCH: begin
                if (mem_ack) begin
                    if (redirect || pend_valid) begin
                        // Returned word belongs to the old path: drop it and refetch.
                        pc_next         = redirect ? redirect_pc : pend_pc;
                        pend_valid_next = 1'b0;
                    end else begin
                        insn_next       = mem_rdata;
                        insn_pc_next    = pc;
                        pc_next         = pc + PC_WIDTH'(1);
                        insn_valid_next = 1'b1;
                        state_next      = DELIVER;
                    end
                end else if (redirect) begin
                    pend_valid_next = 1'b1;
                    pend_pc_next    = redirect_pc;
                end
            end
            DELIVER: begin
                if (redirect || insn_ready) begin
                    insn_valid_next = 1'b0;
                    if (redirect) pc_next = redirect_pc;
                    state_next = halt ? IDLE : FETCH;
                end
            end
            default: state_next = IDLE;
        endcase

        mem_req_next = (state_next == FETCH);
        busy_next    = (state_next != IDLE);
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a simple memory responder.
module tb_fetch_ctrl;

    localparam int unsigned PW = 20;
    localparam int unsigned IW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          halt;
    logic          redirect;
    logic [PW-1:0] redirect_pc;
    logic          mem_req;
    logic [PW-1:0] mem_addr;
    logic          mem_ack;
    logic [IW-1:0] mem_rdata;
    logic          insn_valid;
    logic          insn_ready;
    logic [IW-1:0] insn;
    logic [PW-1:0] insn_pc;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // Memory responder: automatic (acks after mem_delay cycles) or manual.
    logic          mem_auto;
    int            mem_delay;
    logic          auto_ack;
    logic [IW-1:0] auto_data;
    int            auto_cnt;
    logic          man_ack;
    logic [IW-1:0] man_data;

    assign mem_ack   = mem_auto ? auto_ack  : man_ack;
    assign mem_rdata = mem_auto ? auto_data : man_data;

    fetch_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .insn_valid  (insn_valid),
        .insn_ready  (insn_ready),
        .insn        (insn),
        .insn_pc     (insn_pc),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    initial begin
        auto_ack  = 1'b0;
        auto_data = '0;
        auto_cnt  = 0;
    end

    always @(posedge clock) begin
        if (mem_req && !auto_ack) begin
            if (auto_cnt + 1 >= mem_delay) begin
                auto_ack  <= 1'b1;
                auto_data <= 16'hA000 + IW'(mem_addr);
                auto_cnt  <= 0;
            end else begin
                auto_cnt <= auto_cnt + 1;
            end
        end else begin
            auto_ack <= 1'b0;
            if (!mem_req) auto_cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        while (!insn_valid && n < bound) begin
            step();
            n++;
        end
        check("wait_valid", 32'(insn_valid), 32'd1);
    endtask

    task automatic do_reset(input logic h);
        reset      = 1'b1;
        halt       = h;
        redirect   = 1'b0;
        man_ack    = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        insn_ready  = 1'b1;
        mem_auto    = 1'b1;
        mem_delay   = 1;
        man_ack     = 1'b0;
        man_data    = '0;

        // Reset state and basic sequential fetch
        do_reset(1'b0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_valid", 32'(insn_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_insn", 32'(insn), 32'd0);
        check("rst_insn_pc", 32'(insn_pc), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        step();
        check("seq_req_c1", 32'(mem_req), 32'd1);
        check("seq_busy_c1", 32'(busy), 32'd1);
        step();
        check("seq_valid_c2", 32'(insn_valid), 32'd0);
        step();
        check("seq_valid_c3", 32'(insn_valid), 32'd1);
        check("seq_insn0", 32'(insn), 32'h0000A000);
        check("seq_pc0", 32'(insn_pc), 32'd0);
        for (int i = 1; i < 3; i++) begin
            step();
            wait_valid(10);
            check("seq_insn", 32'(insn), 32'hA000 + 32'(i));
            check("seq_pc", 32'(insn_pc), 32'(i));
        end

        // Slow memory and stalled decode
        insn_ready = 1'b0;
        mem_delay  = 4;
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("slow_req", 32'(mem_req), 32'd1);
            check("slow_addr", 32'(mem_addr), 32'd0);
            check("slow_ack", 32'(mem_ack), 32'd0);
        end
        step();
        check("slow_ack_c5", 32'(mem_ack), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_valid", 32'(insn_valid), 32'd1);
            check("stall_insn", 32'(insn), 32'h0000A000);
            check("stall_pc", 32'(insn_pc), 32'd0);
            check("stall_req", 32'(mem_req), 32'd0);
        end
        insn_ready = 1'b1;
        step();
        check("xfer_valid", 32'(insn_valid), 32'd0);
        check("xfer_req", 32'(mem_req), 32'd1);
        check("xfer_next_addr", 32'(mem_addr), 32'd1);
        mem_delay = 1;
        wait_valid(10);
        check("xfer_insn1", 32'(insn), 32'h0000A001);
        check("xfer_pc1", 32'(insn_pc), 32'd1);

        // Redirect while a request to 0x00005 waits for its ack
        mem_auto = 1'b0;
        do_reset(1'b1);
        redirect    = 1'b1;
        redirect_pc = 20'h00005;
        step();
        redirect = 1'b0;
        check("idle_redir_req", 32'(mem_req), 32'd0);
        check("idle_redir_busy", 32'(busy), 32'd0);
        halt = 1'b0;
        step();
        check("pend_addr_5", 32'(mem_addr), 32'h5);
        check("pend_req", 32'(mem_req), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 20'h00100;
        step();
        redirect = 1'b0;
        check("pend_addr_hold", 32'(mem_addr), 32'h5);
        man_ack  = 1'b1;
        man_data = 16'hA005;
        step();
        man_ack = 1'b0;
        check("pend_new_addr", 32'(mem_addr), 32'h100);
        check("pend_req2", 32'(mem_req), 32'd1);
        check("pend_no_valid", 32'(insn_valid), 32'd0);
        mem_auto = 1'b1;
        wait_valid(10);
        check("pend_insn", 32'(insn), 32'h0000A100);
        check("pend_insn_pc", 32'(insn_pc), 32'h100);

        // PC wrap at all-ones
        do_reset(1'b1);
        redirect    = 1'b1;
        redirect_pc = 20'hFFFFF;
        step();
        redirect = 1'b0;
        halt     = 1'b0;
        step();
        check("wrap_addr", 32'(mem_addr), 32'hFFFFF);
        wait_valid(10);
        check("wrap_insn_pc", 32'(insn_pc), 32'hFFFFF);
        check("wrap_insn", 32'(insn), 32'h00009FFF);
        step();
        check("wrap_next_addr", 32'(mem_addr), 32'h0);
        check("wrap_next_req", 32'(mem_req), 32'd1);

        // Halt raised while a fetch is outstanding
        mem_delay = 3;
        do_reset(1'b0);
        step();
        step();
        halt = 1'b1;
        wait_valid(10);
        check("halt_insn", 32'(insn), 32'h0000A000);
        check("halt_busy_dlv", 32'(busy), 32'd1);
        step();
        check("halt_idle_busy", 32'(busy), 32'd0);
        check("halt_idle_valid", 32'(insn_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("halt_no_req", 32'(mem_req), 32'd0);
            step();
        end
        halt = 1'b0;
        step();
        check("unhalt_req", 32'(mem_req), 32'd1);
        check("unhalt_addr", 32'(mem_addr), 32'd1);

        // Reset during FETCH with a late ack
        mem_auto = 1'b0;
        do_reset(1'b0);
        step();
        check("rf_req_before", 32'(mem_req), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rf_req", 32'(mem_req), 32'd0);
        check("rf_valid", 32'(insn_valid), 32'd0);
        check("rf_addr", 32'(mem_addr), 32'd0);
        man_ack  = 1'b1;
        man_data = 16'hDEAD;
        step();
        man_ack = 1'b0;
        check("rf_late_addr", 32'(mem_addr), 32'd0);
        check("rf_late_valid", 32'(insn_valid), 32'd0);
        check("rf_late_insn", 32'(insn), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
